// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Brief    : Multi-cycle memory stage with a strobe/done data-memory handshake.
//            Detects timeouts and, with MEM_ALIGN_CHECK_EN defined, rejects
//            misaligned word accesses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [15:0] addr,
    input  logic [15:0] read2Data,
    input  logic        mem_stall,
    input  logic        mem_done,
    input  logic [15:0] mem_data_in,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_out,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] memResult,
    output logic        done_out,
    output logic        busy,
    output logic        err
);

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_isLoad;
    logic [7:0]  r_count;
    logic [15:0] r_memResult;
    logic        r_err;

    logic [7:0]  w_countNext;
    logic [7:0]  w_countInc;
    logic        w_timeout;
    logic        w_misaligned;
    logic        w_accept;
    logic        w_loadDone;
    logic        w_timeoutHit;
    logic        w_alignErr;
    logic        w_rd;
    logic        w_wr;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = addr[0];
`else
    assign w_misaligned = 1'b0;
`endif

    // Saturating increment: a stuck memory must never wrap the counter.
    assign w_countInc = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
    assign w_timeout  = (w_countInc >= C_TIMEOUT);

    always_comb begin
        w_stateNext  = r_state;
        w_countNext  = r_count;
        w_accept     = 1'b0;
        w_loadDone   = 1'b0;
        w_timeoutHit = 1'b0;
        w_alignErr   = 1'b0;
        w_rd         = 1'b0;
        w_wr         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid_in) begin
                    if (memRead | memWrite) begin
                        if (w_misaligned) begin
                            w_alignErr  = 1'b1;
                            w_stateNext = S_DONE;
                        end else begin
                            w_accept    = 1'b1;
                            w_countNext = 8'd0;
                            w_stateNext = S_ISSUE;
                        end
                    end else begin
                        w_stateNext = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                w_countNext = w_countInc;
                if (w_timeout) begin
                    w_timeoutHit = 1'b1;
                    w_stateNext  = S_DONE;
                end else if (!mem_stall) begin
                    w_rd        = r_isLoad;
                    w_wr        = ~r_isLoad;
                    w_stateNext = S_WAIT;
                end
            end
            S_WAIT: begin
                // A completion in the timeout cycle still counts as success.
                if (mem_done) begin
                    w_loadDone  = r_isLoad;
                    w_stateNext = S_DONE;
                end else begin
                    w_countNext = w_countInc;
                    if (w_timeout) begin
                        w_timeoutHit = 1'b1;
                        w_stateNext  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_isLoad    <= 1'b0;
            r_count     <= 8'd0;
            r_memResult <= 16'h0000;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
            if (w_accept) begin
                r_addr   <= addr;
                r_wdata  <= read2Data;
                r_isLoad <= memRead;
            end
            if (w_loadDone) begin
                r_memResult <= mem_data_in;
            end else if (w_timeoutHit && r_isLoad) begin
                r_memResult <= 16'h0000;
            end
            if (w_timeoutHit || w_alignErr) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_addr     = r_addr;
    assign mem_data_out = r_wdata;
    assign mem_rd       = w_rd;
    assign mem_wr       = w_wr;
    assign memResult    = r_memResult;
    assign done_out     = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);
    assign err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Directed, scoreboarded bench for mem_stage (default and
//            TIMEOUT_CYCLES=4 instances, each with its own reset).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        rstTo;
    logic        valid_in;
    logic        memRead;
    logic        memWrite;
    logic [15:0] addr;
    logic [15:0] read2Data;
    logic        mem_stall;
    logic        mem_done;
    logic [15:0] mem_data_in;

    logic [15:0] memAddr,   memAddrT;
    logic [15:0] memDataOut, memDataOutT;
    logic        memRd,     memRdT;
    logic        memWr,     memWrT;
    logic [15:0] memResult, memResultT;
    logic        doneOut,   doneOutT;
    logic        busy,      busyT;
    logic        err,       errT;

    int          nCmp = 0;
    int          nErr = 0;
    logic [15:0] sbQ[$];

    mem_stage dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .memRead(memRead),
        .memWrite(memWrite), .addr(addr), .read2Data(read2Data),
        .mem_stall(mem_stall), .mem_done(mem_done), .mem_data_in(mem_data_in),
        .mem_addr(memAddr), .mem_data_out(memDataOut), .mem_rd(memRd),
        .mem_wr(memWr), .memResult(memResult), .done_out(doneOut),
        .busy(busy), .err(err)
    );

    mem_stage #(.TIMEOUT_CYCLES(4)) dutTo (
        .clk(clk), .rst(rstTo), .valid_in(valid_in), .memRead(memRead),
        .memWrite(memWrite), .addr(addr), .read2Data(read2Data),
        .mem_stall(mem_stall), .mem_done(mem_done), .mem_data_in(mem_data_in),
        .mem_addr(memAddrT), .mem_data_out(memDataOutT), .mem_rd(memRdT),
        .mem_wr(memWrT), .memResult(memResultT), .done_out(doneOutT),
        .busy(busyT), .err(errT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard: every finished transaction on the default instance pops one result.
    always @(negedge clk) begin
        if (!rst && doneOut) begin
            if (sbQ.size() == 0) begin
                nCmp++;
                nErr++;
                $error("FAIL sb_unexpected_done observed=1 expected=0");
            end else begin
                chk("sb_memResult", memResult, sbQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rstTo = 1'b1;
        valid_in = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        addr = 16'h0; read2Data = 16'h0;
        mem_stall = 1'b0; mem_done = 1'b0; mem_data_in = 16'h0;
        step(); step();
        settle();
        chk("reset_busy", {15'd0, busy}, 16'd0);
        chk("reset_done", {15'd0, doneOut}, 16'd0);
        chk("reset_memResult", memResult, 16'h0000);
        chk("reset_mem_addr", memAddr, 16'h0000);
        chk("reset_err", {15'd0, err}, 16'd0);
        rst = 1'b0;
        step();

        // Reset while a load is outstanding in WAIT
        valid_in = 1'b1; memRead = 1'b1; addr = 16'h0055;
        step(); valid_in = 1'b0; settle();
        chk("rstmid_rd_issue", {15'd0, memRd}, 16'd1);
        step(); settle();
        chk("rstmid_busy_wait", {15'd0, busy}, 16'd1);
        rst = 1'b1; settle();
        chk("rstmid_rd", {15'd0, memRd}, 16'd0);
        chk("rstmid_wr", {15'd0, memWr}, 16'd0);
        chk("rstmid_busy", {15'd0, busy}, 16'd0);
        chk("rstmid_done", {15'd0, doneOut}, 16'd0);
        chk("rstmid_addr", memAddr, 16'h0000);
        step(); rst = 1'b0;
        step(); settle();
        chk("rstmid_idle_busy", {15'd0, busy}, 16'd0);

        // Load 0x0010 -> 0xBEEF, done at T+3
        valid_in = 1'b1; memRead = 1'b1; addr = 16'h0010;
        sbQ.push_back(16'hBEEF);
        step(); valid_in = 1'b0; addr = 16'hFFFF; settle();
        chk("load_rd_t1", {15'd0, memRd}, 16'd1);
        chk("load_wr_t1", {15'd0, memWr}, 16'd0);
        chk("load_addr_t1", memAddr, 16'h0010);
        step(); mem_done = 1'b1; mem_data_in = 16'hBEEF; settle();
        chk("load_rd_t2", {15'd0, memRd}, 16'd0);
        chk("load_done_t2", {15'd0, doneOut}, 16'd0);
        step(); mem_done = 1'b0; mem_data_in = 16'h0; settle();
        chk("load_done_t3", {15'd0, doneOut}, 16'd1);
        chk("load_result_t3", memResult, 16'hBEEF);
        step(); settle();
        chk("load_done_t4", {15'd0, doneOut}, 16'd0);
        chk("load_result_hold", memResult, 16'hBEEF);
        chk("load_busy_t4", {15'd0, busy}, 16'd0);

        // Store with three stall cycles, strobe at T+4 only
        valid_in = 1'b1; memRead = 1'b0; memWrite = 1'b1;
        addr = 16'h0020; read2Data = 16'h1234; mem_stall = 1'b1;
        sbQ.push_back(16'hBEEF);
        step(); valid_in = 1'b0; read2Data = 16'h0; settle();
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("store_stall_wr_t%0d", i), {15'd0, memWr}, 16'd0);
            if (i < 3) begin
                step(); settle();
            end
        end
        step(); mem_stall = 1'b0; settle();
        chk("store_wr_t4", {15'd0, memWr}, 16'd1);
        chk("store_rd_t4", {15'd0, memRd}, 16'd0);
        chk("store_data_t4", memDataOut, 16'h1234);
        chk("store_addr_t4", memAddr, 16'h0020);
        step(); mem_done = 1'b1; mem_data_in = 16'h5555; settle();
        chk("store_wr_t5", {15'd0, memWr}, 16'd0);
        step(); mem_done = 1'b0; mem_data_in = 16'h0; settle();
        chk("store_done_t6", {15'd0, doneOut}, 16'd1);
        chk("store_result", memResult, 16'hBEEF);
        step(); memWrite = 1'b0;

        // Pass-through, then a valid_in during DONE is ignored
        valid_in = 1'b1; memRead = 1'b0; memWrite = 1'b0;
        sbQ.push_back(16'hBEEF);
        step(); memRead = 1'b1; addr = 16'h0030; settle();
        chk("pass_done_t1", {15'd0, doneOut}, 16'd1);
        chk("pass_rd_t1", {15'd0, memRd}, 16'd0);
        step(); valid_in = 1'b0; memRead = 1'b0; settle();
        chk("pass_busy_t2", {15'd0, busy}, 16'd0);
        chk("pass_done_t2", {15'd0, doneOut}, 16'd0);
        step(); settle();
        chk("pass_ignored_rd", {15'd0, memRd}, 16'd0);
        chk("pass_ignored_busy", {15'd0, busy}, 16'd0);

        // Misaligned load at 0x0003
        valid_in = 1'b1; memRead = 1'b1; addr = 16'h0003;
`ifdef MEM_ALIGN_CHECK_EN
        sbQ.push_back(16'hBEEF);
        step(); valid_in = 1'b0; settle();
        chk("align_done_t1", {15'd0, doneOut}, 16'd1);
        chk("align_rd_t1", {15'd0, memRd}, 16'd0);
        chk("align_err", {15'd0, err}, 16'd1);
        step(); settle();
        chk("align_busy_t2", {15'd0, busy}, 16'd0);
`else
        sbQ.push_back(16'h7777);
        step(); valid_in = 1'b0; settle();
        chk("align_rd_t1", {15'd0, memRd}, 16'd1);
        chk("align_addr_t1", memAddr, 16'h0003);
        step(); mem_done = 1'b1; mem_data_in = 16'h7777;
        step(); mem_done = 1'b0; mem_data_in = 16'h0; settle();
        chk("align_done_t3", {15'd0, doneOut}, 16'd1);
        chk("align_err", {15'd0, err}, 16'd0);
        step();
`endif
        memRead = 1'b0;
        step();
        chk("sb_empty_main", 16'(sbQ.size()), 16'd0);

        // Timeout instance (TIMEOUT_CYCLES=4); the default instance is held in reset
        rst = 1'b1; rstTo = 1'b0;
        step();
        valid_in = 1'b1; memRead = 1'b1; addr = 16'h0040;
        step(); valid_in = 1'b0; settle();
        chk("to_pre_rd", {15'd0, memRdT}, 16'd1);
        step(); mem_done = 1'b1; mem_data_in = 16'hABCD;
        step(); mem_done = 1'b0; mem_data_in = 16'h0; settle();
        chk("to_pre_result", memResultT, 16'hABCD);
        chk("to_pre_err", {15'd0, errT}, 16'd0);
        step();
        valid_in = 1'b1; memRead = 1'b1; addr = 16'h0042;
        step(); valid_in = 1'b0; settle();
        chk("to_rd_t1", {15'd0, memRdT}, 16'd1);
        step(); step(); step(); settle();
        chk("to_busy_t4", {15'd0, busyT}, 16'd1);
        chk("to_done_t4", {15'd0, doneOutT}, 16'd0);
        chk("to_err_t4", {15'd0, errT}, 16'd0);
        step(); settle();
        chk("to_done_t5", {15'd0, doneOutT}, 16'd1);
        chk("to_err_t5", {15'd0, errT}, 16'd1);
        chk("to_result_t5", memResultT, 16'h0000);
        step(); settle();
        chk("to_done_t6", {15'd0, doneOutT}, 16'd0);
        chk("to_busy_t6", {15'd0, busyT}, 16'd0);
        valid_in = 1'b1; addr = 16'h0044;
        step(); valid_in = 1'b0; settle();
        chk("to_next_rd", {15'd0, memRdT}, 16'd1);
        step(); mem_done = 1'b1; mem_data_in = 16'h2468;
        step(); mem_done = 1'b0; mem_data_in = 16'h0; settle();
        chk("to_next_done", {15'd0, doneOutT}, 16'd1);
        chk("to_next_result", memResultT, 16'h2468);
        chk("to_next_err_sticky", {15'd0, errT}, 16'd1);
        memRead = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

`default_nettype wire
